// File: rtl/rv_dbg_pkg.sv
// Shared definitions for the debug-side register-file initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_dbg_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 32;
    localparam int DEFAULT_XLEN = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HALT    = 3'd1,
        ACCESS  = 3'd2,
        RESP    = 3'd3,
        RELEASE = 3'd4
    } dbg_state_t;

endpackage

// File: rtl/regfile_dbg_port.sv
// Debug initiator: halts the core, then reads/writes register-file beats and returns one response per beat.
// Latency: accept -> HALT (1) -> ACCESS (1) -> RESP, i.e. rsp_valid 3 cycles after accept when halt_ack is already high; 2 cycles/beat in bursts.
// Backpressure: cmd_ready only in IDLE; rsp_ready low parks the FSM in RESP with no further register access.
//
// Ports: clk/rst (sync, active-high); cmd_* valid/ready command channel (write, addr, len-1, wdata);
//        rsp_* valid/ready response channel (rdata, err); halt_req/halt_ack core quiesce handshake;
//        rf_own port-mux select plus rf_rsel/rf_rdata read port and rf_wen/rf_wsel/rf_wdat write port.
module regfile_dbg_port
    import rv_dbg_pkg::*;
#(
    parameter int XLEN         = DEFAULT_XLEN,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [REG_ADDR_W-1:0] cmd_addr,
    input  logic [REG_ADDR_W-1:0] cmd_len,
    input  logic [XLEN-1:0]       cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_err,
    output logic                  halt_req,
    input  logic                  halt_ack,
    output logic                  rf_own,
    output logic [REG_ADDR_W-1:0] rf_rsel,
    input  logic [XLEN-1:0]       rf_rdata,
    output logic                  rf_wen,
    output logic [REG_ADDR_W-1:0] rf_wsel,
    output logic [XLEN-1:0]       rf_wdat
);

    // Counter runs 0 .. HALT_TIMEOUT-1; the cycle it holds the last value is
    // the HALT_TIMEOUT-th cycle without an ack.
    localparam int              TO_W    = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(HALT_TIMEOUT - 1);

    dbg_state_t            state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  write_q, write_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [REG_ADDR_W-1:0] beats_q, beats_d;   // beats remaining after the current one
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [TO_W-1:0]       tcnt_q, tcnt_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  err_q, err_d;

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            beats_q     <= '0;
            wdata_q     <= '0;
            tcnt_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            beats_q     <= beats_d;
            wdata_q     <= wdata_d;
            tcnt_q      <= tcnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid && cmd_ready_q) state_d = HALT;
            HALT:    if (halt_ack) state_d = ACCESS;
                     else if (tcnt_q == TO_LAST) state_d = RESP;
            ACCESS:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = (beats_q != '0) ? ACCESS : RELEASE;
            RELEASE: if (!halt_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        beats_d = beats_q;
        wdata_d = wdata_q;
        tcnt_d  = tcnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        // Registered ready: low for the first cycle out of reset, high whenever the FSM sits in IDLE.
        cmd_ready_d = (state_d == IDLE);
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    beats_d = cmd_len;
                    wdata_d = cmd_wdata;
                    tcnt_d  = '0;
                end
            end
            HALT: begin
                if (!halt_ack) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == TO_LAST) begin
                        // Timeout: one error response, rest of the burst is dropped.
                        rdata_d = '0;
                        err_d   = 1'b1;
                        beats_d = '0;
                    end
                end
            end
            ACCESS: begin
                rdata_d = write_q ? '0 : rf_rdata;
                err_d   = write_q && (addr_q == '0);
            end
            RESP: begin
                if (rsp_ready && (beats_q != '0)) begin
                    beats_d = beats_q - 1'b1;
                    addr_d  = addr_q + 1'b1;   // x31 wraps to x0
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from the state register and datapath flops only
    always_comb begin
        cmd_ready = cmd_ready_q;
        halt_req  = (state_q == HALT) || (state_q == ACCESS) || (state_q == RESP);
        rf_own    = (state_q == ACCESS);
        rf_rsel   = rf_own ? addr_q : '0;
        rf_wsel   = rf_own ? addr_q : '0;
        rf_wdat   = rf_own ? wdata_q : '0;
        rf_wen    = rf_own && write_q && (addr_q != '0);
        rsp_valid = (state_q == RESP);
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_err   = rsp_valid && err_q;
    end

endmodule

// File: tb/tb_regfile_dbg_port.sv
`timescale 1ns/1ps
module tb_regfile_dbg_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr, cmd_len;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        halt_req, halt_ack, ack_block;
    logic        rf_own, rf_wen;
    logic [4:0]  rf_rsel, rf_wsel;
    logic [31:0] rf_rdata, rf_wdat;

    logic [31:0] rf_mem [32];
    logic [31:0] shadow [32];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];

    int   n_vec  = 0;
    int   n_fail = 0;
    logic seen_own, seen_wen;

    always #5 clk = ~clk;

    regfile_dbg_port #(.XLEN(32), .HALT_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .rf_own(rf_own), .rf_rsel(rf_rsel), .rf_rdata(rf_rdata),
        .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat)
    );

    // Core model: acks as soon as asked unless blocked; register file with x0 hardwired to zero.
    assign halt_ack = halt_req && !ack_block;
    assign rf_rdata = (rf_rsel == 5'd0) ? 32'd0 : rf_mem[rf_rsel];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
        end else if (rf_wen && rf_wsel != 5'd0) begin
            rf_mem[rf_wsel] <= rf_wdat;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; pops the scoreboard if a response handshake happens at this edge.
    task automatic tick();
        logic        hs;
        logic [31:0] d;
        logic        e;
        rsp_t        r;
        hs = rsp_valid && rsp_ready && !rst;
        d  = rsp_rdata;
        e  = rsp_err;
        @(posedge clk);
        #1;
        seen_own = seen_own | rf_own;
        seen_wen = seen_wen | rf_wen;
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                r = exp_q.pop_front();
                chk("rsp_rdata", d, r.rdata);
                chk("rsp_err", 32'(e), 32'(r.err));
            end
        end
    endtask

    task automatic send(input logic w, input logic [4:0] a, input logic [4:0] l,
                        input logic [31:0] wd, input bit push);
        logic       acc;
        logic [4:0] ba;
        rsp_t       r;
        acc = 1'b0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_wdata = wd;
        if (push) begin
            for (int b = 0; b <= int'(l); b++) begin
                ba = a + 5'(b);
                if (w) begin
                    r.rdata = 32'd0;
                    r.err   = (ba == 5'd0);
                    if (ba != 5'd0) shadow[ba] = wd;
                end else begin
                    r.rdata = shadow[ba];
                    r.err   = 1'b0;
                end
                exp_q.push_back(r);
            end
        end
        for (int k = 0; k < 100; k++) begin
            acc = cmd_ready;
            tick();
            if (acc) break;
        end
        chk("cmd_accept", 32'(acc), 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && k < 400) begin
            tick();
            k++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_wdata = '0; rsp_ready = 1'b1; ack_block = 1'b0; seen_own = 1'b0; seen_wen = 1'b0;
        for (int i = 0; i < 32; i++) shadow[i] = 32'd0;

        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_halt_req", 32'(halt_req), 32'd0);
        chk("rst_rf_own", 32'(rf_own), 32'd0);
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rf_wdat", rf_wdat, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single write x5, cycle-accurate
        send(1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 1'b1);
        chk("c1_halt_req", 32'(halt_req), 32'd1);
        chk("c1_rf_own", 32'(rf_own), 32'd0);
        tick();
        chk("c2_rf_own", 32'(rf_own), 32'd1);
        chk("c2_rf_wen", 32'(rf_wen), 32'd1);
        chk("c2_rf_wsel", 32'(rf_wsel), 32'd5);
        chk("c2_rf_wdat", rf_wdat, 32'hDEADBEEF);
        tick();
        chk("c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("c3_rsp_err", 32'(rsp_err), 32'd0);
        chk("c3_rf_wen", 32'(rf_wen), 32'd0);
        drain();
        send(1'b0, 5'd5, 5'd0, 32'd0, 1'b1);
        drain();

        // x0 write is rejected, x0 read is fine
        seen_wen = 1'b0;
        send(1'b1, 5'd0, 5'd0, 32'h12345678, 1'b1);
        drain();
        chk("x0_no_wen", 32'(seen_wen), 32'd0);
        send(1'b0, 5'd0, 5'd0, 32'd0, 1'b1);
        drain();

        // xi = i+2, then burst read across the x31 -> x0 wrap
        for (int i = 1; i < 32; i++) send(1'b1, 5'(i), 5'd0, 32'(i + 2), 1'b1);
        drain();
        send(1'b0, 5'd30, 5'd3, 32'd0, 1'b1);
        drain();

        // Halt timeout
        ack_block = 1'b1;
        seen_own  = 1'b0;
        exp_q.push_back('{rdata: 32'd0, err: 1'b1});
        send(1'b0, 5'd3, 5'd2, 32'd0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            if (halt_req) n++;
            tick();
        end
        chk("to_halt_cycles", 32'(n), 32'd8);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        drain();
        chk("to_no_own", 32'(seen_own), 32'd0);
        chk("to_halt_dropped", 32'(halt_req), 32'd0);
        ack_block = 1'b0;

        // Response stall mid-burst, then reset during RESP
        send(1'b0, 5'd10, 5'd3, 32'd0, 1'b1);
        n = 0;
        while (exp_q.size() > 3 && n < 50) begin tick(); n++; end
        while (!rsp_valid && n < 50) begin tick(); n++; end
        rsp_ready = 1'b0;
        seen_own  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", rsp_rdata, exp_q[0].rdata);
        end
        chk("stall_no_access", 32'(seen_own), 32'd0);
        rsp_ready = 1'b1;
        n = 0;
        while (!(exp_q.size() == 1 && rsp_valid) && n < 50) begin tick(); n++; end
        chk("last_beat_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_halt_req", 32'(halt_req), 32'd0);
        chk("mid_rst_rf_own", 32'(rf_own), 32'd0);
        chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        exp_q.delete();
        rst = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
